// File: rtl/sr_latch_monitor.sv
// rtl/sr_latch_monitor.sv - passive checker for an active-high NOR SR latch
module sr_latch_monitor #(
   parameter int SETTLE_MAX = 4,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s,
   input  logic             r,
   input  logic             q,
   input  logic             qb,
   output logic             known,
   output logic             exp_q,
   output logic             err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] set_cnt,
   output logic [CNT_W-1:0] reset_cnt,
   output logic [CNT_W-1:0] forbid_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [1:0] ST_UNKNOWN = 2'd0;
   localparam logic [1:0] ST_SETTLE  = 2'd1;
   localparam logic [1:0] ST_STABLE  = 2'd2;
   localparam logic [1:0] ST_FORBID  = 2'd3;

   // Timer value on which a still-mismatching SETTLE gives up.
   localparam logic [7:0]       TIMER_LAST = 8'(SETTLE_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   // Counters stick at all-ones so a long soak never reports a wrapped value.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // Two-stage synchronizers, packed as {s, r, q, qb}.
   logic [3:0] meta_q, meta_d;
   logic [3:0] sync_q, sync_d;

   logic [1:0] prev_sr_q, prev_sr_d;
   logic [1:0] state_q, state_d;
   logic [7:0] timer_q, timer_d;
   logic       expq_q, expq_d;
   logic       mismatch_q, mismatch_d;
   logic       err_q, err_d;
   logic       sticky_q, sticky_d;
   logic       known_q, known_d;
   logic [CNT_W-1:0] set_cnt_q, set_cnt_d;
   logic [CNT_W-1:0] reset_cnt_q, reset_cnt_d;
   logic [CNT_W-1:0] forbid_cnt_q, forbid_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic       ss, rs, qs, qbs;
   logic [1:0] sr_now;
   logic       sr_change;
   logic       outs_ok;

   // Synchronizer next-state: raw pins into stage one, stage one into stage two.
   always_comb begin
      meta_d = {s, r, q, qb};
      sync_d = meta_q;
   end

   assign ss  = sync_q[3];
   assign rs  = sync_q[2];
   assign qs  = sync_q[1];
   assign qbs = sync_q[0];

   assign sr_now    = {ss, rs};
   assign sr_change = (sr_now != prev_sr_q);
   assign outs_ok   = (qs == expq_q) && (qbs == ~expq_q);

   // Latch model, settle timer, output checking and event counting.
   always_comb begin
      prev_sr_d    = sr_now;
      state_d      = state_q;
      timer_d      = timer_q;
      expq_d       = expq_q;
      mismatch_d   = mismatch_q;
      err_d        = 1'b0;
      set_cnt_d    = set_cnt_q;
      reset_cnt_d  = reset_cnt_q;
      forbid_cnt_d = forbid_cnt_q;
      err_cnt_d    = err_cnt_q;

      if (sr_change) begin
         // A command change always takes priority over a pending timeout.
         case (sr_now)
            2'b10: begin
               state_d    = ST_SETTLE;
               timer_d    = 8'd0;
               expq_d     = 1'b1;
               mismatch_d = 1'b0;
               set_cnt_d  = sat_inc(set_cnt_q);
            end
            2'b01: begin
               state_d     = ST_SETTLE;
               timer_d     = 8'd0;
               expq_d      = 1'b0;
               mismatch_d  = 1'b0;
               reset_cnt_d = sat_inc(reset_cnt_q);
            end
            2'b11: begin
               state_d      = ST_FORBID;
               forbid_cnt_d = sat_inc(forbid_cnt_q);
            end
            default: begin
               // Release to hold: leaving 11 is a race, so the state is lost.
               if (state_q == ST_FORBID) begin
                  state_d = ST_UNKNOWN;
               end else if (state_q == ST_SETTLE) begin
                  // Timer keeps running but parks on its last value so the
                  // timeout still fires on the next quiet cycle.
                  if (timer_q != TIMER_LAST) begin
                     timer_d = timer_q + 8'd1;
                  end
               end
            end
         endcase
      end else begin
         case (state_q)
            ST_SETTLE: begin
               if (outs_ok) begin
                  state_d = ST_STABLE;
               end else if (timer_q == TIMER_LAST) begin
                  err_d      = 1'b1;
                  err_cnt_d  = sat_inc(err_cnt_q);
                  mismatch_d = 1'b1;
                  state_d    = ST_STABLE;
               end else begin
                  timer_d = timer_q + 8'd1;
               end
            end
            ST_STABLE: begin
               // Report only the edge into mismatch; a persisting fault is one error.
               if (!outs_ok) begin
                  if (!mismatch_q) begin
                     err_d      = 1'b1;
                     err_cnt_d  = sat_inc(err_cnt_q);
                     mismatch_d = 1'b1;
                  end
               end else begin
                  mismatch_d = 1'b0;
               end
            end
            default: begin
               // UNKNOWN and FORBID: nothing to check against.
            end
         endcase
      end

      sticky_d = sticky_q | err_d;
      known_d  = (state_d == ST_SETTLE) || (state_d == ST_STABLE);
   end

   // All state registers, cleared together by the synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q       <= 4'd0;
         sync_q       <= 4'd0;
         prev_sr_q    <= 2'b00;
         state_q      <= ST_UNKNOWN;
         timer_q      <= 8'd0;
         expq_q       <= 1'b0;
         mismatch_q   <= 1'b0;
         err_q        <= 1'b0;
         sticky_q     <= 1'b0;
         known_q      <= 1'b0;
         set_cnt_q    <= '0;
         reset_cnt_q  <= '0;
         forbid_cnt_q <= '0;
         err_cnt_q    <= '0;
      end else begin
         meta_q       <= meta_d;
         sync_q       <= sync_d;
         prev_sr_q    <= prev_sr_d;
         state_q      <= state_d;
         timer_q      <= timer_d;
         expq_q       <= expq_d;
         mismatch_q   <= mismatch_d;
         err_q        <= err_d;
         sticky_q     <= sticky_d;
         known_q      <= known_d;
         set_cnt_q    <= set_cnt_d;
         reset_cnt_q  <= reset_cnt_d;
         forbid_cnt_q <= forbid_cnt_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign known      = known_q;
   assign exp_q      = expq_q;
   assign err        = err_q;
   assign err_sticky = sticky_q;
   assign set_cnt    = set_cnt_q;
   assign reset_cnt  = reset_cnt_q;
   assign forbid_cnt = forbid_cnt_q;
   assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_sr_latch_monitor.sv
// tb/tb_sr_latch_monitor.sv - scoreboard bench for sr_latch_monitor
module tb_sr_latch_monitor;

   localparam int SETTLE_MAX = 4;
   localparam int CNT_W      = 3;
   localparam int CMAX       = 7;
   localparam int L          = 24;

   logic clk = 1'b0;
   logic rst, s, r, q, qb;
   logic known, exp_q, err, err_sticky;
   logic [CNT_W-1:0] set_cnt, reset_cnt, forbid_cnt, err_cnt;

   always #5 clk = ~clk;

   sr_latch_monitor #(.SETTLE_MAX(SETTLE_MAX), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .s(s), .r(r), .q(q), .qb(qb),
      .known(known), .exp_q(exp_q), .err(err), .err_sticky(err_sticky),
      .set_cnt(set_cnt), .reset_cnt(reset_cnt),
      .forbid_cnt(forbid_cnt), .err_cnt(err_cnt)
   );

   typedef struct {
      int set_c;
      int reset_c;
      int forbid_c;
      int err_c;
      bit known;
      bit expq;
      int errs;
      bit sticky;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   err_seen = 0;
   logic chk_req = 1'b0;

   // Reference model: event totals and the latch value implied by the commands.
   int       m_set, m_reset, m_forbid, m_err, phase_errs;
   bit       m_known, m_expq;
   bit [1:0] m_sr;

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_set = 0; m_reset = 0; m_forbid = 0; m_err = 0; phase_errs = 0;
      m_known = 1'b0; m_expq = 1'b0; m_sr = 2'b00;
   endtask

   task automatic push_expect();
      exp_t e;
      e.set_c    = sat(m_set);
      e.reset_c  = sat(m_reset);
      e.forbid_c = sat(m_forbid);
      e.err_c    = sat(m_err);
      e.known    = m_known;
      e.expq     = m_expq;
      e.errs     = phase_errs;
      e.sticky   = (m_err > 0);
      sb.push_back(e);
      phase_errs = 0;
      chk_req = 1'b1;
      step();
      chk_req = 1'b0;
   endtask

   function automatic bit outs_match(input bit qv, input bit qbv, input bit e);
      return (qv == e) && (qbv == !e);
   endfunction

   // Apply command sr; the latch outputs move to (fq,fqb) lag cycles later.
   task automatic do_sr_phase(input bit [1:0] sr, input int lag, input bit fq, input bit fqb);
      int errs = 0;
      bit old_ok, final_ok;
      if (sr != m_sr) begin
         case (sr)
            2'b10, 2'b01: begin
               if (sr == 2'b10) m_set++; else m_reset++;
               m_known = 1'b1;
               m_expq  = sr[1];
               old_ok   = outs_match(q, qb, m_expq) && (lag >= 2);
               final_ok = outs_match(fq, fqb, m_expq);
               if (old_ok) errs = final_ok ? 0 : 1;
               else        errs = (final_ok && lag <= SETTLE_MAX) ? 0 : 1;
            end
            2'b11: begin
               m_forbid++;
               m_known = 1'b0;
            end
            default: begin
               if (m_sr == 2'b11) m_known = 1'b0;
            end
         endcase
      end else if (m_known) begin
         errs = (outs_match(q, qb, m_expq) && !outs_match(fq, fqb, m_expq)) ? 1 : 0;
      end
      m_sr = sr;
      m_err += errs;
      phase_errs += errs;
      s = sr[1];
      r = sr[0];
      for (int i = 0; i < L; i++) begin
         if (i == lag) begin
            q  = fq;
            qb = fqb;
         end
         step();
      end
      push_expect();
   endtask

   // Invert q for g cycles and restore it, commands unchanged.
   task automatic do_glitch(input int g);
      int errs = 0;
      bit cur_ok, gl_ok;
      cur_ok = outs_match(q, qb, m_expq);
      gl_ok  = outs_match(!q, qb, m_expq);
      if (m_known) errs = (cur_ok != gl_ok) ? 1 : 0;
      m_err += errs;
      phase_errs += errs;
      q = ~q;
      repeat (g) step();
      q = ~q;
      repeat (L - g) step();
      push_expect();
   endtask

   // Correct latch response for command sr given its present outputs.
   task automatic good_outs(input bit [1:0] sr, output bit fq, output bit fqb);
      case (sr)
         2'b10:   begin fq = 1'b1; fqb = 1'b0; end
         2'b01:   begin fq = 1'b0; fqb = 1'b1; end
         2'b11:   begin fq = 1'b0; fqb = 1'b0; end
         default: begin fq = q;    fqb = qb;   end
      endcase
   endtask

   task automatic correct_phase(input bit [1:0] sr, input int lag);
      bit fq, fqb;
      good_outs(sr, fq, fqb);
      do_sr_phase(sr, lag, fq, fqb);
   endtask

   task automatic random_phase();
      int op;
      bit fq, fqb;
      bit [1:0] pair;
      op = $urandom_range(0, 4);
      if (op == 4) begin
         do_glitch($urandom_range(1, 4));
      end else begin
         good_outs(op[1:0], fq, fqb);
         if (op[1:0] == m_sr && op[1:0] != 2'b11 && $urandom_range(0, 1) == 1) begin
            fq = q;
            fqb = qb;
         end else if ((op == 1 || op == 2) && $urandom_range(0, 3) == 0) begin
            pair = {fq, fqb} ^ 2'($urandom_range(1, 3));
            fq = pair[1];
            fqb = pair[0];
         end
         do_sr_phase(op[1:0], $urandom_range(0, 7), fq, fqb);
      end
   endtask

   // Monitor: counts err pulses and compares against the scoreboard on request.
   always @(negedge clk) begin
      if (err === 1'b1) err_seen++;
      if (chk_req) begin
         if (sb.size() == 0) begin
            chk("scoreboard_entry", 0, 1);
         end else begin
            mon_e = sb.pop_front();
            chk("set_cnt", int'(set_cnt), mon_e.set_c);
            chk("reset_cnt", int'(reset_cnt), mon_e.reset_c);
            chk("forbid_cnt", int'(forbid_cnt), mon_e.forbid_c);
            chk("err_cnt", int'(err_cnt), mon_e.err_c);
            chk("known", int'(known), int'(mon_e.known));
            if (mon_e.known) chk("exp_q", int'(exp_q), int'(mon_e.expq));
            chk("err_pulses", err_seen, mon_e.errs);
            chk("err_sticky", int'(err_sticky), int'(mon_e.sticky));
            err_seen = 0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit fq, fqb;
      rst = 1'b1; s = 1'b0; r = 1'b0; q = 1'b0; qb = 1'b0;
      model_reset();
      repeat (2) step();
      rst = 1'b0;
      push_expect();

      // Directed: reset command, set with following latch, stuck-output set.
      correct_phase(2'b01, 1);
      correct_phase(2'b10, 2);
      correct_phase(2'b01, 0);
      do_sr_phase(2'b10, 0, 1'b0, 1'b1);
      do_sr_phase(2'b10, 0, 1'b1, 1'b0);
      do_glitch(4);

      // Forbidden-entry sequence with a well-behaved latch.
      correct_phase(2'b00, 3);
      correct_phase(2'b11, 3);
      correct_phase(2'b10, 3);
      correct_phase(2'b11, 3);
      correct_phase(2'b00, 3);
      correct_phase(2'b11, 3);
      correct_phase(2'b01, 3);

      // Late but valid settle and one just past the limit.
      correct_phase(2'b10, SETTLE_MAX);
      good_outs(2'b01, fq, fqb);
      do_sr_phase(2'b01, SETTLE_MAX + 1, fq, fqb);

      for (int i = 0; i < 60; i++) random_phase();

      // Reset in the middle of a settle window that would otherwise time out.
      correct_phase(2'b01, 0);
      s = 1'b1; r = 1'b0;
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      s = 1'b0; r = 1'b0;
      model_reset();
      push_expect();
      correct_phase(2'b00, 0);

      for (int i = 0; i < 15; i++) random_phase();

      repeat (3) step();
      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sr_latch_monitor.md
Name: sr_latch_monitor

Overview:
- Synchronous checker that sits on the observing side of an SR latch.
- Samples the latch's S/R drive and its Q/QB outputs, models the expected NOR-latch state, and flags outputs that fail to settle or that drift.
- Counts set, reset, forbidden and error events for bench and on-board self-test use.
- Drops into any latch bench or DUT wrapper as a passive reader; it never drives the latch.

Parameters:
- SETTLE_MAX, 4: cycles after a synchronized S/R change within which Q/QB must reach the expected value (1..255).
- CNT_W, 8: width of each event counter.

Ports:
- clk  input  1  single system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- s  input  1  latch set input (asynchronous to clk)
- r  input  1  latch reset input (asynchronous to clk)
- q  input  1  latch Q (asynchronous)
- qb  input  1  latch QB (asynchronous)
- known  output  1  1 when the expected latch state is determined
- exp_q  output  1  expected Q, valid only when known=1
- err  output  1  one-cycle pulse per detected error
- err_sticky  output  1  set by any err, cleared only by rst
- set_cnt  output  CNT_W  number of set commands seen
- reset_cnt  output  CNT_W  number of reset commands seen
- forbid_cnt  output  CNT_W  number of entries into S=R=1
- err_cnt  output  CNT_W  number of errors

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Clears all registers: synchronizers, prev_sr=00, state=UNKNOWN, timer=0, all counters 0.
  - Outputs are known=0, exp_q=0, err=0, err_sticky=0.
  - Reset asserted mid-operation discards everything on that edge. No err is generated during or on the cycle after reset.
- Input sampling:
  - s, r, q and qb each pass through a 2-flop synchronizer.
  - Everything below uses the synchronized values ss, rs, qs, qbs.
  - A change is any cycle where {ss,rs} != prev_sr. prev_sr updates every cycle.
- Latch semantics (active-high NOR latch):
  - 10 = set, 01 = reset, 00 = hold.
  - 11 = forbidden; Q=QB=0 is expected but not checked.
- States:
  - UNKNOWN: known=0.
  - SETTLE: known=1; timer counts up from 0.
  - STABLE: known=1.
  - FORBID: known=0.
- Transitions on a change, identical from every state:
  - 10: go to SETTLE, exp_q<=1, set_cnt++.
  - 01: go to SETTLE, exp_q<=0, reset_cnt++.
  - 11: go to FORBID, forbid_cnt++.
  - 00:
    - from UNKNOWN: stay in UNKNOWN.
    - from FORBID: go to UNKNOWN (race, state lost).
    - from SETTLE: stay in SETTLE; the timer keeps running.
    - from STABLE: stay in STABLE.
- Transitions with no change:
  - SETTLE:
    - If qs==exp_q and qbs==~exp_q, go to STABLE.
    - Otherwise, if timer==SETTLE_MAX-1: err=1, err_cnt++, go to STABLE with the mismatch flag set.
    - Otherwise timer++.
  - STABLE:
    - On the cycle outputs go from matching to mismatching: err=1, err_cnt++, set the mismatch flag.
    - No further err while the mismatch persists; the flag clears when outputs match again.
  - UNKNOWN and FORBID: no output checking.
- Change handling inside SETTLE: a change to 10/01 restarts the timer at 0 with the new exp_q.
- Mismatch flag: cleared on entry to SETTLE.
- Counters: all saturate at 2^CNT_W-1 and never wrap.
- Simultaneous events: when a change and a settle timeout occur in the same cycle, the change wins and no err is raised.
- Latency:
  - Latch activity to synchronized view: 2 cycles.
  - Counter update: 1 cycle after the change is detected.
  - err is registered, asserted the cycle after detection.
- Combinational outputs: none. All outputs come straight from registers.

Test Plan:
- Reset, then hold s=0, r=1 with q=0, qb=1 → within 4 cycles reset_cnt=1, known=1, exp_q=0; err never asserts.
- Drive 10 with the latch model following after 2 cycles → set_cnt=1, exp_q=1; state reaches STABLE and err_cnt=0.
- Drive 10 but hold q=0, qb=1 (SETTLE_MAX=4) → exactly one err pulse about 6–7 cycles after s rises; err_cnt=1, err_sticky=1; restoring q=1, qb=0 raises no further err.
- Sequence 00, 11, 10, 11, 00, 11, 01 at 100-cycle spacing with a correct latch model:
  - Final counts: forbid_cnt=3, set_cnt=1, reset_cnt=1, err_cnt=0.
  - known=0 after 11→00, and known=1 after the final 01.
- In STABLE with exp_q=1, glitch q to 0 for 5 cycles → a single err pulse and err_cnt+1; with CNT_W=2, repeating the glitch 5 times gives err_cnt=3 (saturated).
- Assert rst for 1 cycle mid-SETTLE → next cycle all counters are 0, known=0, err_sticky=0, and no err pulse occurs.
